enemy_spawn_scheduler: RTL and testbench
========================================

Name: enemy_spawn_scheduler

Overview:
Controls enemy tank slots for one level. It decides when each slot is alive, exploding, waiting or empty. It picks a spawn point for each new enemy, in round-robin order and skipping blocked points. It counts kills and raises level_clear once every enemy in the level's quota is destroyed. It sits above the per-enemy tank blocks, driving their enable and start location, and takes their destroyed flags back.

Parameters:
NUM_SLOTS, 3, number of concurrently drivable enemy tanks
NUM_POINTS, 3, number of spawn points
TOTAL_ENEMIES, 20, enemies per level (spawn quota)
BOOM_TICKS, 8, refresh ticks an enemy stays in explosion state
RESPAWN_TICKS, 120, refresh ticks a slot waits after explosion before it can respawn

Ports:
clk_50MHz  in  1  system clock
reset  in  1  asynchronous, active-low
refresh_tick  in  1  one-clk pulse per frame; all scheduling advances only on it
freeze  in  1  1 = hold all counters and states (pause / tank destroyed)
enemy_hit  in  NUM_SLOTS  per-slot destroyed flag from enemy blocks
point_blocked  in  NUM_POINTS  1 = spawn point occupied by the tank or an enemy
slot_alive  out  NUM_SLOTS  slot drives a live, movable enemy
slot_boom  out  NUM_SLOTS  slot shows explosion sprite
spawn_valid  out  1  one-clk pulse when a slot is spawned
spawn_slot  out  2  slot index for spawn_valid
spawn_point  out  2  spawn point index for spawn_valid
x_spawn  out  10  x of chosen point (32 / 192 / 512 for points 0/1/2)
y_spawn  out  10  y of chosen point (32 for all)
remaining  out  5  enemies not yet spawned
kills  out  5  enemies destroyed this level
level_clear  out  1  sticky level-complete flag

Behaviour:
- Reset (async, active-low):
  - all slots EMPTY; remaining = TOTAL_ENEMIES; kills = 0; rr pointer = 0.
  - spawn_valid = 0; spawn_slot = 0; spawn_point = 0; x_spawn = 32; y_spawn = 32.
  - slot_alive = 0; slot_boom = 0; level_clear = 0.
- Per-slot FSM states: EMPTY, ALIVE, BOOM, WAIT. A per-slot tick counter (8 bit) is used in BOOM and WAIT.
- Nothing changes on clocks without refresh_tick, or while freeze = 1 (a tick with freeze = 1 is ignored entirely). Exception: spawn_valid clears to 0 one clk after it is asserted.
- ALIVE -> BOOM:
  - on a tick with enemy_hit[i] = 1; kills += 1 (saturate at 31); counter cleared.
  - Several slots hit on the same tick each count as a kill.
  - enemy_hit on a non-ALIVE slot is ignored.
- BOOM -> WAIT: on the tick when counter = BOOM_TICKS-1; counter cleared.
- WAIT -> EMPTY: on the tick when counter = RESPAWN_TICKS-1.
- EMPTY -> ALIVE (spawn):
  - At most one spawn per tick.
  - Candidate slot: the lowest-index slot that was EMPTY at the start of the tick; requires remaining > 0.
  - Point search starts at rr; take the first point with point_blocked = 0, checking rr, rr+1, ... modulo NUM_POINTS.
  - If all points are blocked: no spawn; retry on the next tick.
  - On spawn: slot becomes ALIVE; remaining -= 1; rr = chosen point + 1 modulo NUM_POINTS.
  - spawn_valid = 1 for exactly one clk, registered on the tick clock. spawn_slot, spawn_point, x_spawn and y_spawn are valid with it and hold afterwards.
- A slot that reaches EMPTY on a tick is not eligible to spawn until the next tick (one-tick minimum gap).
- slot_alive[i] = (state == ALIVE); slot_boom[i] = (state == BOOM). Both are registered.
- level_clear:
  - Set on the tick where remaining = 0, kills = TOTAL_ENEMIES and no slot is ALIVE or BOOM.
  - Sticky until reset. While it is set, no spawns occur.
- Widths: counter compares are on 8-bit unsigned; remaining and kills are 5-bit; TOTAL_ENEMIES ≤ 31.

Decomposition:
- Shared package holds:
  - slot_state_t enum (EMPTY, ALIVE, BOOM, WAIT);
  - spawn coordinate constants X_SPAWN_0/1/2 = 32/192/512 and Y_SPAWN = 32;
  - a spawn-point lookup function.
- One sub-module, enemy_slot_fsm: a per-slot state plus counter, with inputs tick, hit and grant and outputs state and became_empty. It is instantiated NUM_SLOTS times.
- Arbitration, round-robin point search and the kill/remaining counters stay in the top module.

Test Plan:
- Reset, no blocks, 3 ticks -> spawns on ticks 1/2/3 with slot 0/1/2 at points 0/1/2, x_spawn 32/192/512; remaining = 17; slot_alive = 3'b111.
- Hit slot 1 on a tick -> slot_boom[1] = 1 for 8 ticks; then WAIT 120 ticks; EMPTY; respawn on the following tick at point 0 (rr wrapped); kills = 1.
- point_blocked = 3'b111 with slot 0 EMPTY -> no spawn_valid and remaining unchanged. Release point 2 -> spawn next tick at point 2.
- enemy_hit = 3'b111 on one tick -> kills += 3; all three slots in BOOM simultaneously.
- freeze = 1 for 50 ticks in mid BOOM (counter = 4) -> counter and slot_boom held; after release, BOOM ends 4 ticks later.
- TOTAL_ENEMIES = 4: kill all 4 -> level_clear = 1 on the tick the last BOOM/WAIT condition is met, no further spawn_valid. Async reset mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/enemy_spawn_scheduler_pkg.sv
// enemy_spawn_scheduler_pkg: shared slot state type, spawn coordinates and point lookup.
package enemy_spawn_scheduler_pkg;

    typedef enum logic [1:0] {EMPTY, ALIVE, BOOM, WAIT} slot_state_t;

    localparam logic [9:0] X_SPAWN_0 = 10'd32;
    localparam logic [9:0] X_SPAWN_1 = 10'd192;
    localparam logic [9:0] X_SPAWN_2 = 10'd512;
    localparam logic [9:0] Y_SPAWN   = 10'd32;

    function automatic logic [9:0] spawn_x(input logic [1:0] point);
        return point == 2'd0 ? X_SPAWN_0 : point == 2'd1 ? X_SPAWN_1 : X_SPAWN_2;
    endfunction

endpackage

// File: rtl/enemy_slot_fsm.sv
// enemy_slot_fsm: one enemy slot lifecycle (EMPTY -> ALIVE -> BOOM -> WAIT -> EMPTY).
//   clk_50MHz, reset (async, active-low)
//   tick         : gated frame tick (already excludes freeze)
//   hit          : destroyed flag from the enemy block, honoured only while ALIVE
//   grant        : spawn grant from the scheduler, honoured only while EMPTY
//   state        : current slot state
//   became_empty : high during the tick on which WAIT expires
module enemy_slot_fsm
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter int BOOM_TICKS    = 8,
    parameter int RESPAWN_TICKS = 120
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    input  logic        tick,
    input  logic        hit,
    input  logic        grant,
    output slot_state_t state,
    output logic        became_empty
);

    localparam logic [7:0] BOOM_LAST = 8'(BOOM_TICKS - 1);
    localparam logic [7:0] WAIT_LAST = 8'(RESPAWN_TICKS - 1);

    slot_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        became_empty = 1'b0;
        if (tick) begin
            case (state_q)
                EMPTY: state_d = grant ? ALIVE : EMPTY;
                ALIVE: if (hit) begin
                    state_d = BOOM;
                    cnt_d   = '0;
                end
                BOOM: if (cnt_q == BOOM_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                WAIT: if (cnt_q == WAIT_LAST) begin
                    state_d      = EMPTY;
                    became_empty = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler: schedules enemy slots, round-robin spawn points, kill counting and level clear.
//   clk_50MHz, reset (async, active-low)
//   refresh_tick  : one-clk frame pulse, the only time anything advances
//   freeze        : ignore ticks entirely while high
//   enemy_hit     : per-slot destroyed flags
//   point_blocked : per-point occupied flags
//   slot_alive, slot_boom : per-slot state decode
//   spawn_valid, spawn_slot, spawn_point, x_spawn, y_spawn : spawn event (pulse) and its held data
//   remaining, kills, level_clear : level progress
module enemy_spawn_scheduler
    import enemy_spawn_scheduler_pkg::*;
#(
    parameter int NUM_SLOTS     = 3,
    parameter int NUM_POINTS    = 3,
    parameter int TOTAL_ENEMIES = 20,
    parameter int BOOM_TICKS    = 8,
    parameter int RESPAWN_TICKS = 120
) (
    input  logic                  clk_50MHz,
    input  logic                  reset,
    input  logic                  refresh_tick,
    input  logic                  freeze,
    input  logic [NUM_SLOTS-1:0]  enemy_hit,
    input  logic [NUM_POINTS-1:0] point_blocked,
    output logic [NUM_SLOTS-1:0]  slot_alive,
    output logic [NUM_SLOTS-1:0]  slot_boom,
    output logic                  spawn_valid,
    output logic [1:0]            spawn_slot,
    output logic [1:0]            spawn_point,
    output logic [9:0]            x_spawn,
    output logic [9:0]            y_spawn,
    output logic [4:0]            remaining,
    output logic [4:0]            kills,
    output logic                  level_clear
);

    logic                 tick;
    slot_state_t          state [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] became_empty, grant;
    logic                 cand_valid, pt_valid, do_spawn;
    logic [1:0]           cand, pt;
    logic [5:0]           n_hits, ksum;

    logic [4:0] remaining_q, remaining_d, kills_q, kills_d;
    logic [1:0] rr_q, rr_d, spawn_slot_q, spawn_slot_d, spawn_point_q, spawn_point_d;
    logic [9:0] x_spawn_q, x_spawn_d;
    logic       level_clear_q, level_clear_d, spawn_valid_q;

    assign tick = refresh_tick & ~freeze;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        enemy_slot_fsm #(
            .BOOM_TICKS   (BOOM_TICKS),
            .RESPAWN_TICKS(RESPAWN_TICKS)
        ) u_slot (
            .clk_50MHz   (clk_50MHz),
            .reset       (reset),
            .tick        (tick),
            .hit         (enemy_hit[g]),
            .grant       (grant[g]),
            .state       (state[g]),
            .became_empty(became_empty[g])
        );
        assign slot_alive[g] = state[g] == ALIVE;
        assign slot_boom[g]  = state[g] == BOOM;
        assign grant[g]      = do_spawn && cand == 2'(g);
    end

    // Scans run high-to-low so the last match left standing is the lowest slot
    // and the first unblocked point at or after rr.
    always_comb begin
        cand_valid = 1'b0;
        cand       = '0;
        pt_valid   = 1'b0;
        pt         = '0;
        n_hits     = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (state[i] == EMPTY && !became_empty[i]) begin
                cand_valid = 1'b1;
                cand       = 2'(i);
            end
            n_hits = n_hits + 6'(slot_alive[i] & enemy_hit[i]);
        end
        for (int k = NUM_POINTS - 1; k >= 0; k--) begin
            if (!point_blocked[(int'(rr_q) + k) % NUM_POINTS]) begin
                pt_valid = 1'b1;
                pt       = 2'((int'(rr_q) + k) % NUM_POINTS);
            end
        end
    end

    assign do_spawn = tick && !level_clear_q && remaining_q != '0 && cand_valid && pt_valid;
    assign ksum     = {1'b0, kills_q} + n_hits;

    always_comb begin
        remaining_d   = do_spawn ? remaining_q - 5'd1 : remaining_q;
        kills_d       = !tick ? kills_q : ksum > 6'd31 ? 5'd31 : ksum[4:0];
        rr_d          = !do_spawn ? rr_q : pt == 2'(NUM_POINTS - 1) ? 2'd0 : pt + 2'd1;
        spawn_slot_d  = do_spawn ? cand : spawn_slot_q;
        spawn_point_d = do_spawn ? pt : spawn_point_q;
        x_spawn_d     = do_spawn ? spawn_x(pt) : x_spawn_q;
        // Condition is judged on start-of-tick values: the level is done once the
        // quota is spent, every kill is in, and nothing is still alive or exploding.
        level_clear_d = level_clear_q || (tick && remaining_q == '0 &&
                        kills_q == 5'(TOTAL_ENEMIES) && !(|(slot_alive | slot_boom)));
    end

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            remaining_q   <= 5'(TOTAL_ENEMIES);
            kills_q       <= '0;
            rr_q          <= '0;
            level_clear_q <= 1'b0;
            spawn_valid_q <= 1'b0;
            spawn_slot_q  <= '0;
            spawn_point_q <= '0;
            x_spawn_q     <= X_SPAWN_0;
        end else begin
            remaining_q   <= remaining_d;
            kills_q       <= kills_d;
            rr_q          <= rr_d;
            level_clear_q <= level_clear_d;
            spawn_valid_q <= do_spawn;
            spawn_slot_q  <= spawn_slot_d;
            spawn_point_q <= spawn_point_d;
            x_spawn_q     <= x_spawn_d;
        end
    end

    assign remaining   = remaining_q;
    assign kills       = kills_q;
    assign level_clear = level_clear_q;
    assign spawn_valid = spawn_valid_q;
    assign spawn_slot  = spawn_slot_q;
    assign spawn_point = spawn_point_q;
    assign x_spawn     = x_spawn_q;
    assign y_spawn     = Y_SPAWN;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// tb_enemy_spawn_scheduler: scoreboard bench for enemy_spawn_scheduler against a behavioural slot model.
module tb_enemy_spawn_scheduler;

    localparam int TOTAL = 20;

    logic       clk_50MHz = 1'b0;
    logic       reset = 1'b0;
    logic       refresh_tick = 1'b0;
    logic       freeze = 1'b0;
    logic [2:0] enemy_hit = '0;
    logic [2:0] point_blocked = '0;
    logic [2:0] slot_alive, slot_boom;
    logic       spawn_valid, level_clear;
    logic [1:0] spawn_slot, spawn_point;
    logic [9:0] x_spawn, y_spawn;
    logic [4:0] remaining, kills;

    enemy_spawn_scheduler dut (
        .clk_50MHz    (clk_50MHz),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .freeze       (freeze),
        .enemy_hit    (enemy_hit),
        .point_blocked(point_blocked),
        .slot_alive   (slot_alive),
        .slot_boom    (slot_boom),
        .spawn_valid  (spawn_valid),
        .spawn_slot   (spawn_slot),
        .spawn_point  (spawn_point),
        .x_spawn      (x_spawn),
        .y_spawn      (y_spawn),
        .remaining    (remaining),
        .kills        (kills),
        .level_clear  (level_clear)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    typedef struct {int slot; int pt; int x;} spawn_t;
    spawn_t exp_q[$];
    spawn_t e;

    int checks = 0;
    int errors = 0;
    int st[3], cnt[3];
    int rem, kil, rr, lc;
    bit exp_sv;
    int xs[3] = '{32, 192, 512};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            st[i]  = 0;
            cnt[i] = 0;
        end
        rem = TOTAL;
        kil = 0;
        rr  = 0;
        lc  = 0;
        exp_q.delete();
    endfunction

    // states: 0 EMPTY, 1 ALIVE, 2 BOOM, 3 WAIT
    function automatic void model_step(input logic f, input logic [2:0] h, input logic [2:0] b);
        int ost[3];
        int cand, okil, orem, p;
        bit busy;
        exp_sv = 0;
        if (f) return;
        ost = st;
        okil = kil;
        orem = rem;
        cand = -1;
        busy = 0;
        for (int i = 2; i >= 0; i--) if (ost[i] == 0) cand = i;
        for (int i = 0; i < 3; i++) begin
            if (ost[i] == 1 || ost[i] == 2) busy = 1;
            case (ost[i])
                1: if (h[i]) begin st[i] = 2; cnt[i] = 0; kil = kil < 31 ? kil + 1 : 31; end
                2: if (cnt[i] == 7) begin st[i] = 3; cnt[i] = 0; end else cnt[i]++;
                3: if (cnt[i] == 119) st[i] = 0; else cnt[i]++;
                default: ;
            endcase
        end
        if (lc == 0 && orem > 0 && cand >= 0) begin
            for (int k = 0; k < 3; k++) begin
                p = (rr + k) % 3;
                if (!b[p]) begin
                    st[cand] = 1;
                    rem--;
                    rr = (p + 1) % 3;
                    exp_q.push_back('{cand, p, xs[p]});
                    exp_sv = 1;
                    break;
                end
            end
        end
        if (orem == 0 && okil == TOTAL && !busy) lc = 1;
    endfunction

    function automatic logic [2:0] vec(input int s);
        logic [2:0] v = '0;
        for (int i = 0; i < 3; i++) v[i] = st[i] == s;
        return v;
    endfunction

    task automatic tick(input logic f, input logic [2:0] h, input logic [2:0] b);
        @(negedge clk_50MHz);
        refresh_tick  = 1'b1;
        freeze        = f;
        enemy_hit     = h;
        point_blocked = b;
        model_step(f, h, b);
        @(negedge clk_50MHz);
        refresh_tick = 1'b0;
        freeze       = 1'b0;
        enemy_hit    = '0;
        check("spawn_valid", spawn_valid, exp_sv);
        check("slot_alive", slot_alive, vec(1));
        check("slot_boom", slot_boom, vec(2));
        check("kills", kills, kil);
        check("remaining", remaining, rem);
        check("level_clear", level_clear, lc);
        @(negedge clk_50MHz);
    endtask

    always @(negedge clk_50MHz) begin
        if (reset && spawn_valid) begin
            if (exp_q.size() == 0) begin
                check("spawn_unexpected", spawn_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("spawn_slot", spawn_slot, e.slot);
                check("spawn_point", spawn_point, e.pt);
                check("x_spawn", x_spawn, e.x);
                check("y_spawn", y_spawn, 32);
            end
        end
    end

    task automatic check_reset_values();
        check("rst_alive", slot_alive, 0);
        check("rst_boom", slot_boom, 0);
        check("rst_spawn_valid", spawn_valid, 0);
        check("rst_spawn_slot", spawn_slot, 0);
        check("rst_spawn_point", spawn_point, 0);
        check("rst_x", x_spawn, 32);
        check("rst_y", y_spawn, 32);
        check("rst_remaining", remaining, TOTAL);
        check("rst_kills", kills, 0);
        check("rst_level_clear", level_clear, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk_50MHz);
        check_reset_values();
        reset = 1'b1;

        repeat (3) tick(1'b0, 3'b000, 3'b000);
        check("first_remaining", remaining, 17);
        check("first_alive", slot_alive, 3'b111);

        tick(1'b0, 3'b010, 3'b000);
        check("hit1_boom", slot_boom[1], 1'b1);
        repeat (7) tick(1'b0, 3'b000, 3'b000);
        check("hit1_boom_last", slot_boom[1], 1'b1);
        tick(1'b0, 3'b000, 3'b000);
        check("hit1_boom_done", slot_boom[1], 1'b0);
        repeat (120) tick(1'b0, 3'b000, 3'b000);
        check("hit1_empty", slot_alive[1], 1'b0);
        tick(1'b0, 3'b000, 3'b000);
        check("respawn_point0", spawn_point, 0);
        check("respawn_slot1", spawn_slot, 1);
        check("kills_one", kills, 1);

        tick(1'b0, 3'b001, 3'b111);
        repeat (131) tick(1'b0, 3'b000, 3'b111);
        check("blocked_remaining", remaining, 16);
        tick(1'b0, 3'b000, 3'b011);
        check("unblock_point2", spawn_point, 2);
        check("unblock_slot0", spawn_slot, 0);

        tick(1'b0, 3'b111, 3'b000);
        check("triple_kills", kills, 5);
        check("triple_boom", slot_boom, 3'b111);
        repeat (4) tick(1'b0, 3'b000, 3'b000);
        repeat (50) tick(1'b1, 3'b111, 3'b000);
        check("freeze_boom", slot_boom, 3'b111);
        repeat (3) tick(1'b0, 3'b000, 3'b000);
        check("thaw_boom", slot_boom, 3'b111);
        tick(1'b0, 3'b000, 3'b000);
        check("thaw_boom_end", slot_boom, 3'b000);

        for (int n = 0; n < 3000 && lc == 0; n++) tick(1'b0, 3'b111, 3'b000);
        check("clear_flag", level_clear, 1'b1);
        check("clear_kills", kills, TOTAL);
        check("clear_remaining", remaining, 0);
        repeat (5) tick(1'b0, 3'b111, 3'b000);
        check("clear_sticky", level_clear, 1'b1);

        @(negedge clk_50MHz);
        #2 reset = 1'b0;
        #1 check_reset_values();
        model_reset();
        @(negedge clk_50MHz);
        reset = 1'b1;
        tick(1'b0, 3'b000, 3'b000);
        check("post_reset_point", spawn_point, 0);
        check("post_reset_remaining", remaining, 19);

        repeat (2) @(negedge clk_50MHz);
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
